// File: rtl/next_q_max_search.sv
// Reads every action Q-value of one state over a sync-read RAM port and returns the signed max and its action index.
// Latency: accept->out_valid NUM_ACTIONS+2 cycles (terminal: 1). out_valid/out_max/out_action hold until out_ready.
module next_q_max_search #(
  parameter int DATA_W      = 32,
  parameter int STATE_W     = 8,
  parameter int NUM_ACTIONS = 4,
  parameter int ACTION_W    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  output logic                        start_ready_o,
  input  logic [STATE_W-1:0]          state_idx_i,
  input  logic                        terminal_i,
  output logic                        mem_rd_en_o,
  output logic [STATE_W+ACTION_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0]           mem_rd_data_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [DATA_W-1:0]           out_max_o,
  output logic [ACTION_W-1:0]         out_action_o
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  localparam logic [ACTION_W-1:0] LAST_ACT = ACTION_W'(NUM_ACTIONS - 1);

  state_e                state_q, state_d;
  logic [STATE_W-1:0]    sidx_q;
  logic [ACTION_W-1:0]   rd_cnt_q;
  logic                  rd_vld_q;
  logic [ACTION_W-1:0]   rd_idx_q;
  logic [DATA_W-1:0]     max_q;
  logic [ACTION_W-1:0]   act_q;
  logic                  accept;

  assign accept = start_i && (state_q == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = terminal_i ? DONE : READ;
      READ:    if (rd_cnt_q == LAST_ACT) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_ready_o = (state_q == IDLE);
    mem_rd_en_o   = (state_q == READ);
    out_valid_o   = (state_q == DONE);
    mem_addr_o    = '0;
    if (state_q == READ) mem_addr_o = {sidx_q, rd_cnt_q};
  end

  // rd_vld_q/rd_idx_q mark the cycle in which RAM data belongs to a read we issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sidx_q   <= '0;
      rd_cnt_q <= '0;
      rd_vld_q <= 1'b0;
      rd_idx_q <= '0;
      max_q    <= '0;
      act_q    <= '0;
    end else begin
      rd_vld_q <= mem_rd_en_o;
      rd_idx_q <= rd_cnt_q;
      if (accept) begin
        sidx_q   <= state_idx_i;
        rd_cnt_q <= '0;
        if (terminal_i) begin
          max_q <= '0;
          act_q <= '0;
        end
      end else if (state_q == READ) begin
        rd_cnt_q <= rd_cnt_q + ACTION_W'(1);
      end
      // strict greater-than keeps the lower index on ties
      if (rd_vld_q && ((rd_idx_q == '0) ||
                       ($signed(mem_rd_data_i) > $signed(max_q)))) begin
        max_q <= mem_rd_data_i;
        act_q <= rd_idx_q;
      end
    end
  end

  assign out_max_o    = max_q;
  assign out_action_o = act_q;

endmodule
